// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: FSM state encodings and the default byte width.
// Also used by uart_tx and uart_rx, so the encodings must stay fixed.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after rr_ptr.
// Also reused by the uart_rx consumer mux.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    function automatic logic [IW-1:0] rot(
        input logic [IW-1:0] base,
        input int            k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IW'(s);
    endfunction

    // Scan from farthest to nearest so the closest hit to rr_ptr wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[rot(rr_ptr, k)]) begin
                grant = rot(rr_ptr, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Tracks tx_busy for frame start/finish and aborts if uart_tx never starts.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    active_id,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    uart_state_e           state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         active_id_q, active_id_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [IW-1:0]         pick_id;
    logic                  pick_valid;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_id),
        .valid  (pick_valid)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
        if (int'(g) == NUM_REQ - 1) begin
            return '0;
        end
        return g + IW'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        active_id_d = active_id_q;
        tx_data_d   = tx_data_q;
        ack_d       = '0;
        done_d      = '0;
        tx_start_d  = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (pick_valid) begin
                    ack_d       = ONE_HOT0 << pick_id;
                    tx_data_d   = req_data[pick_id*DATA_WIDTH +: DATA_WIDTH];
                    active_id_d = pick_id;
                    tx_start_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // uart_tx never took the byte: drop it, move on.
                    err_d    = 1'b1;
                    rr_ptr_d = next_idx(active_id_q);
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d   = ONE_HOT0 << active_id_q;
                    rr_ptr_d = next_idx(active_id_q);
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            active_id_q <= '0;
            tx_data_q   <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign active_id   = active_id_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx model.
// The model can be switched to a stub whose tx_busy stays low.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int T   = 16;
    localparam int CPB = 4;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [1:0]     active_id;
    logic           busy;
    logic           err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (W),
        .BUSY_TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done != 0) last_done_cyc = cyc;

    // uart_tx model: 8N1, CPB clocks per bit, line decoded at mid-bit
    bit         uart_en = 1'b1;
    logic       overlap;
    logic       m_busy;
    logic [9:0] m_sh;
    logic [9:0] m_rx;
    logic [2:0] m_clk;
    logic [3:0] m_bit;
    logic [7:0] rxq[$];
    wire        ser_line = m_busy ? m_sh[0] : 1'b1;

    assign tx_busy = uart_en & m_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_sh    <= '1;
            m_rx    <= '0;
            m_clk   <= '0;
            m_bit   <= '0;
            overlap <= 1'b0;
        end else begin
            if (tx_start && m_busy) overlap <= 1'b1;
            if (!m_busy) begin
                if (tx_start && uart_en) begin
                    m_busy <= 1'b1;
                    m_sh   <= {1'b1, tx_data, 1'b0};
                    m_clk  <= '0;
                    m_bit  <= '0;
                end
            end else begin
                if (m_clk == 3'(CPB / 2)) m_rx[m_bit] <= ser_line;
                if (m_clk == 3'(CPB - 1)) begin
                    m_clk <= '0;
                    m_sh  <= {1'b1, m_sh[9:1]};
                    m_bit <= m_bit + 4'd1;
                    if (m_bit == 4'd9) begin
                        m_busy <= 1'b0;
                        rxq.push_back(m_rx[8:1]);
                    end
                end else begin
                    m_clk <= m_clk + 3'd1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] a,
                            output int n);
        a = '0;
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (ack != 0) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req = '0;
        req_data = '0;
        #2;
        tests++;
        if ({ack, done, tx_start, tx_data, active_id, busy, err_timeout} !== '0) begin
            fails++;
            $display("FAIL reset_outs got ack=%b done=%b st=%b data=%h id=%0d busy=%b err=%b want all 0",
                     ack, done, tx_start, tx_data, active_id, busy, err_timeout);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset got busy=%b st=%b want 0 0", busy, tx_start);
        end
    endtask

    task automatic test_single;
        int fall;
        int dn;
        int base;
        logic prev;
        logic [N-1:0] dv;
        base = rxq.size();
        req_data = '0;
        req_data[1*W +: W] = 8'hA5;
        req = 4'b0010;
        tick();
        tests++;
        if (ack !== 4'b0010 || tx_start !== 1'b1 || active_id !== 2'd1 ||
            tx_data !== 8'hA5 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_grant got ack=%b st=%b id=%0d data=%h busy=%b want 0010 1 1 a5 1",
                     ack, tx_start, active_id, tx_data, busy);
        end
        req = '0;
        fall = -1;
        dn = -1;
        dv = '0;
        prev = tx_busy;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (prev && !tx_busy) fall = i;
            if (done != 0) begin
                dn = i;
                dv = done;
                break;
            end
            prev = tx_busy;
        end
        tests++;
        if (fall < 0 || dn != fall + 1 || dv !== 4'b0010) begin
            fails++;
            $display("FAIL single_done got fall=%0d done_at=%0d done=%b want done_at=fall+1 done=0010",
                     fall, dn, dv);
        end
        tests++;
        if (rxq.size() != base + 1 || rxq[base] !== 8'hA5) begin
            fails++;
            $display("FAIL single_line got n=%0d byte=%h want 1 a5",
                     rxq.size() - base, (rxq.size() > base) ? rxq[base] : 8'h00);
        end
    endtask

    task automatic test_round_robin;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [N-1:0] a;
        int n;
        int base;
        bit ok;
        bit line_ok;
        do_reset();
        base = rxq.size();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack(300, a, n);
            if (k == 4) req = '0;
            tests++;
            if (a !== (4'b0001 << exp_id[k]) || tx_data !== exp_b[k] ||
                active_id !== 2'(exp_id[k])) begin
                fails++;
                $display("FAIL rr_grant%0d got ack=%b data=%h id=%0d want id=%0d data=%h",
                         k, a, tx_data, active_id, exp_id[k], exp_b[k]);
            end
            if (k == 1) begin
                tests++;
                if (cyc - last_done_cyc != 1) begin
                    fails++;
                    $display("FAIL rr_gap got done->start=%0d want 1", cyc - last_done_cyc);
                end
            end
        end
        wait_idle(300, ok);
        line_ok = (rxq.size() == base + 5);
        for (int k = 0; k < 5; k++) begin
            if (line_ok && rxq[base + k] !== exp_b[k]) line_ok = 1'b0;
        end
        tests++;
        if (!ok || !line_ok) begin
            fails++;
            $display("FAIL rr_line got idle=%b n=%0d want 1 5 bytes 11 22 33 44 11",
                     ok, rxq.size() - base);
        end
        tests++;
        if (overlap !== 1'b0) begin
            fails++;
            $display("FAIL rr_overlap got %b want 0", overlap);
        end
    endtask

    task automatic test_after_last;
        logic [N-1:0] a;
        int n;
        bit ok;
        req = 4'b0100;
        wait_ack(20, a, n);
        req = '0;
        wait_idle(300, ok);
        tests++;
        if (a !== 4'b0100 || !ok) begin
            fails++;
            $display("FAIL prio_pre got ack=%b idle=%b want 0100 1", a, ok);
        end
        req = 4'b1100;
        wait_ack(20, a, n);
        req = 4'b0100;
        tests++;
        if (a !== 4'b1000 || n != 1) begin
            fails++;
            $display("FAIL prio_first got ack=%b lat=%0d want 1000 1", a, n);
        end
        wait_ack(300, a, n);
        req = '0;
        tests++;
        if (a !== 4'b0100 || tx_data !== 8'h33) begin
            fails++;
            $display("FAIL prio_second got ack=%b data=%h want 0100 33", a, tx_data);
        end
        wait_idle(300, ok);
    endtask

    task automatic test_timeout;
        logic [N-1:0] a;
        int n;
        int k;
        bit dn_seen;
        bit seen;
        do_reset();
        uart_en = 1'b0;
        req = 4'b0011;
        wait_ack(10, a, n);
        tests++;
        if (a !== 4'b0001 || n != 1) begin
            fails++;
            $display("FAIL to_grant got ack=%b lat=%0d want 0001 1", a, n);
        end
        k = 0;
        dn_seen = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            k++;
            if (done != 0) dn_seen = 1'b1;
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || k != T + 1 || busy !== 1'b0 || dn_seen) begin
            fails++;
            $display("FAIL to_pulse got seen=%b cycles=%0d busy=%b done_seen=%b want 1 %0d 0 0",
                     seen, k, busy, dn_seen, T + 1);
        end
        tick();
        tests++;
        if (ack !== 4'b0010 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_next got ack=%b err=%b want 0010 0", ack, err_timeout);
        end
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || done !== '0) begin
            fails++;
            $display("FAIL to_second got seen=%b done=%b want 1 0000", seen, done);
        end
        uart_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_midframe;
        logic [N-1:0] a;
        int n;
        bit ok;
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0010;
        wait_ack(20, a, n);
        req = '0;
        wait_idle(300, ok);
        req = 4'b1000;
        wait_ack(20, a, n);
        req = '0;
        repeat (6) tick();
        tests++;
        if (a !== 4'b1000 || busy !== 1'b1 || active_id !== 2'd3 ||
            tx_data !== 8'h44 || tx_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre got ack=%b busy=%b id=%0d data=%h txb=%b want 1000 1 3 44 1",
                     a, busy, active_id, tx_data, tx_busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({ack, done, tx_start, tx_data, active_id, busy, err_timeout} !== '0) begin
            fails++;
            $display("FAIL mid_async got ack=%b done=%b st=%b data=%h id=%0d busy=%b err=%b want all 0",
                     ack, done, tx_start, tx_data, active_id, busy, err_timeout);
        end
        tick();
        reset_n = 1'b1;
        req = 4'b0101;
        wait_ack(20, a, n);
        req = '0;
        tests++;
        if (a !== 4'b0001 || tx_data !== 8'h11) begin
            fails++;
            $display("FAIL mid_rrptr got ack=%b data=%h want 0001 11", a, tx_data);
        end
        wait_idle(300, ok);
    endtask

    task automatic test_pulse_while_busy;
        logic [N-1:0] a;
        int n;
        int base;
        bit bad_ack;
        bit extra_start;
        base = rxq.size();
        req = 4'b0001;
        wait_ack(20, a, n);
        req = '0;
        tests++;
        if (a !== 4'b0001) begin
            fails++;
            $display("FAIL pulse_grant got ack=%b want 0001", a);
        end
        repeat (5) tick();
        req = 4'b0010;
        tick();
        req = '0;
        bad_ack = 1'b0;
        extra_start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (ack != 0) bad_ack = 1'b1;
            if (tx_start) extra_start = 1'b1;
        end
        tests++;
        if (bad_ack || extra_start) begin
            fails++;
            $display("FAIL pulse_served got ack_seen=%b start_seen=%b want 0 0", bad_ack, extra_start);
        end
        tests++;
        if (rxq.size() != base + 1 || rxq[base] !== 8'h11) begin
            fails++;
            $display("FAIL pulse_line got n=%0d want 1 byte 11", rxq.size() - base);
        end
    endtask

    initial begin
        req = '0;
        req_data = '0;
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_after_last();
        test_timeout();
        test_reset_midframe();
        test_pulse_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
